// File: rtl/serial_in_if.sv
// Bus bundle between the serial_in read master and its host: frame control,
// the SPI pins and the word write port (checksum only with SERIAL_IN_CHECKSUM_EN).
interface serial_in_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              miso;
  logic              sclk;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
`ifdef SERIAL_IN_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  modport master (
    input  start,
    input  miso,
    output sclk,
    output wr_en,
    output wr_addr,
    output wr_data,
    output busy,
`ifdef SERIAL_IN_CHECKSUM_EN
    output checksum,
`endif
    output done
  );

  modport slave (
    output start,
    output miso,
    input  sclk,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  busy,
`ifdef SERIAL_IN_CHECKSUM_EN
    input  checksum,
`endif
    input  done
  );
endinterface

// File: rtl/serial_in.sv
// SPI-style read master: clocks N_WORDS 16-bit words MSB-first out of a sender
// and writes them to a buffer. Define SERIAL_IN_CHECKSUM_EN for a running word sum.
module serial_in #(
  parameter int HALF_PERIOD = 8,
  parameter int N_WORDS     = 1024,
  parameter int ADDR_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  serial_in_if.master   bus
);

  localparam int               WC_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [7:0]       HALF_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(N_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  // The sample point needs 3 sender cycles plus 2 synchronizer cycles inside HIGH.
  generate
    if (HALF_PERIOD < 6 || HALF_PERIOD > 255) begin : g_bad_half_period
      $error("serial_in: HALF_PERIOD must be in 6..255");
    end
    if (N_WORDS < 1 || N_WORDS > 65536) begin : g_bad_n_words
      $error("serial_in: N_WORDS must be in 1..65536");
    end
  endgenerate

  logic [1:0]      state;
  logic [7:0]      half_cnt;
  logic [3:0]      bit_cnt;
  logic [WC_W-1:0] word_cnt;
  logic [15:0]     shift;
  logic            miso_meta;
  logic            miso_s;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the two flops form a real 2-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= bus.miso;
      miso_s    <= miso_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shift       <= '0;
      bus.sclk    <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
`ifdef SERIAL_IN_CHECKSUM_EN
      bus.checksum <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done cycle is already IDLE; a start coinciding with it is dropped.
          if (bus.start && !bus.done) begin
            bit_cnt  <= 4'd15;
            word_cnt <= '0;
            half_cnt <= '0;
            bus.busy <= 1'b1;
            bus.sclk <= 1'b1;
            state    <= S_HIGH;
`ifdef SERIAL_IN_CHECKSUM_EN
            bus.checksum <= '0;
`endif
          end
        end

        S_HIGH: begin
          if (half_cnt == HALF_LAST) begin
            shift[bit_cnt] <= miso_s;
            half_cnt       <= '0;
            bus.sclk       <= 1'b0;
            state          <= S_LOW;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        S_LOW: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (bit_cnt != 4'd0) begin
              bit_cnt  <= bit_cnt - 4'd1;
              bus.sclk <= 1'b1;
              state    <= S_HIGH;
            end else begin
              bus.wr_en   <= 1'b1;
              bus.wr_data <= shift;
              bus.wr_addr <= ADDR_W'(word_cnt);
`ifdef SERIAL_IN_CHECKSUM_EN
              bus.checksum <= bus.checksum + shift;
`endif
              word_cnt <= word_cnt + 1'b1;
              bit_cnt  <= 4'd15;
              if (word_cnt == WORD_LAST) begin
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
                state    <= S_IDLE;
              end else begin
                bus.sclk <= 1'b1;
                state    <= S_HIGH;
              end
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        default: begin
          bus.sclk <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_in.sv
// Self-checking bench for serial_in: a sender model with 3-cycle miso latency
// feeds random and directed frames; writes, sclk rises and done are scored.
module tb_serial_in;

  localparam int HP     = 6;
  localparam int NW     = 3;
  localparam int ADDR_W = 16;

  logic clk;
  logic rst;

  serial_in_if #(.ADDR_W(ADDR_W)) bus ();

  serial_in #(
    .HALF_PERIOD (HP),
    .N_WORDS     (NW),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sender model: each sclk rise k puts bit (15 - k%16) of word k/16 on miso,
  // three clk cycles after the rise.
  logic [15:0] tx_words[$];
  int          tx_pos;

  initial begin
    logic sclk_q;
    int   idx;
    logic [15:0] w;
    sclk_q   = 1'b0;
    tx_pos   = 0;
    bus.miso = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.sclk === 1'b1 && sclk_q === 1'b0) begin
        idx = tx_pos;
        tx_pos++;
        repeat (2) @(posedge clk);
        #1;
        if (idx / 16 < tx_words.size()) begin
          w        = tx_words[idx / 16];
          bus.miso = w[15 - (idx % 16)];
        end else begin
          bus.miso = 1'($urandom);
        end
      end
      sclk_q = bus.sclk;
    end
  end

  // Observation, sampled on the falling edge.
  logic [31:0] wr_q[$];
  int          rise_cnt;
  int          done_cnt;
  int          done_wr;
  logic [15:0] cs_at_done;

  initial begin
    logic sclk_prev;
    sclk_prev  = 1'b0;
    rise_cnt   = 0;
    done_cnt   = 0;
    done_wr    = 0;
    cs_at_done = '0;
    forever begin
      @(negedge clk);
      if (bus.sclk === 1'b1 && sclk_prev === 1'b0) rise_cnt++;
      sclk_prev = bus.sclk;
      if (bus.wr_en === 1'b1) wr_q.push_back({16'(bus.wr_addr), bus.wr_data});
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (bus.wr_en === 1'b1) done_wr++;
`ifdef SERIAL_IN_CHECKSUM_EN
        cs_at_done = bus.checksum;
`endif
      end
    end
  end

  task automatic clear_obs();
    wr_q.delete();
    rise_cnt = 0;
    done_cnt = 0;
    done_wr  = 0;
    tx_pos   = 0;
  endtask

  task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input bit poke_mid, input bit poke_done);
    logic [15:0] exp_w[NW];
    logic [15:0] sum;
    int          t;
    exp_w = '{w0, w1, w2};
    sum   = 16'(w0 + w1 + w2);
    tx_words.delete();
    foreach (exp_w[i]) tx_words.push_back(exp_w[i]);
    clear_obs();

    @(posedge clk) #1 bus.start = 1'b1;
    @(posedge clk) #1 bus.start = 1'b0;
    check("first_sclk_rise", 32'(bus.sclk), 32'd1);
    check("busy_on_start", 32'(bus.busy), 32'd1);
`ifdef SERIAL_IN_CHECKSUM_EN
    check("checksum_cleared", 32'(bus.checksum), 32'd0);
`endif

    if (poke_mid) begin
      repeat ($urandom_range(20, 500)) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk) #1 bus.start = 1'b0;
    end

    t = 0;
    while (bus.done !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("done_within_budget", 32'(bus.done), 32'd1);

    if (poke_done) begin
      bus.start = 1'b1;
      @(posedge clk) #1 bus.start = 1'b0;
      check("start_in_done_ignored_sclk", 32'(bus.sclk), 32'd0);
      check("start_in_done_ignored_busy", 32'(bus.busy), 32'd0);
    end
    repeat (20) @(posedge clk);

    check("write_count", 32'(wr_q.size()), 32'(NW));
    for (int i = 0; i < NW; i++) begin
      if (i < wr_q.size()) check("write_addr_data", wr_q[i], {16'(i), exp_w[i]});
    end
    check("sclk_rises", 32'(rise_cnt), 32'(16 * NW));
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_with_last_wr", 32'(done_wr), 32'd1);
    check("wr_data_held", 32'(bus.wr_data), 32'(w2));
    check("wr_addr_held", 32'(bus.wr_addr), 32'(NW - 1));
    check("idle_sclk", 32'(bus.sclk), 32'd0);
`ifdef SERIAL_IN_CHECKSUM_EN
    check("checksum_at_done", 32'(cs_at_done), 32'(sum));
    check("checksum_held", 32'(bus.checksum), 32'(sum));
`endif
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", 32'(bus.sclk), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
`ifdef SERIAL_IN_CHECKSUM_EN
    check("rst_checksum", 32'(bus.checksum), 32'd0);
`endif
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Directed patterns, then a start mid-frame and one in the done cycle.
    run_frame(16'hA5C3, 16'h0001, 16'(($urandom)), 1'b0, 1'b0);
    run_frame(16'hFFFF, 16'h0000, 16'h8001, 1'b0, 1'b0);
    run_frame(16'hFFFF, 16'h0002, 16'h0000, 1'b1, 1'b1);

    // Abort after 7 bits of word 0, then a normal frame.
    tx_words.delete();
    tx_words.push_back(16'($urandom));
    clear_obs();
    @(posedge clk) #1 bus.start = 1'b1;
    @(posedge clk) #1 bus.start = 1'b0;
    t = 0;
    while (rise_cnt < 7 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("reached_bit_7", 32'(rise_cnt), 32'd7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;
    check("abort_sclk", 32'(bus.sclk), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_wr_en", 32'(bus.wr_en), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    clear_obs();
    repeat (300) @(posedge clk);
    check("abort_no_rises", 32'(rise_cnt), 32'd0);
    check("abort_no_writes", 32'(wr_q.size()), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame(16'h1234, 16'(($urandom)), 16'hFEDC, 1'b0, 1'b0);

    // Random frames.
    for (int i = 0; i < 5; i++) begin
      run_frame(16'($urandom), 16'($urandom), 16'($urandom), 1'(i % 2), 1'(i == 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_in.md
Name: serial_in

Overview:
- SPI-style read master that clocks words out of the `serial_out` sender and writes them into a local buffer.
- Generates `sclk` and samples `miso` MSB-first.
- Assembles 16-bit words and issues one write strobe per word with an incrementing address.
- Sits on the host-side FPGA or debug capture path; reads a frame of `N_WORDS` words per `start` request.

Parameters:
- HALF_PERIOD, 8, `clk` cycles per `sclk` half-period. Legal range is 6..255; values below 6 are a synthesis-time error.
- N_WORDS, 1024, words per frame. Legal range is 1..65536.
- ADDR_W, 16, width of `wr_addr`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to read one frame
- miso  in  1  serial data from the sender (asynchronous to `clk`)
- sclk  out  1  serial clock to the sender; idles low
- wr_en  out  1  one-cycle strobe: `wr_data` and `wr_addr` are valid
- wr_addr  out  ADDR_W  word index within the frame, 0..N_WORDS-1
- wr_data  out  16  assembled word
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse on frame completion
- checksum  out  16  present only with SERIAL_IN_CHECKSUM_EN

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: `sclk`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `checksum`=0. Internal state returns to IDLE and all counters clear.
- `miso` passes through a 2-FF synchronizer (`miso_s`) before use.
- State IDLE:
  - `sclk`=0, `busy`=0.
  - `start`=1 → load bit counter 15, clear word counter and half-period counter.
  - Set `busy`=1 next cycle and go to HIGH.
- State HIGH:
  - `sclk`=1 for HALF_PERIOD cycles.
  - On the last cycle of HIGH, sample `miso_s` into shift-register bit [bit counter] and go to LOW.
  - Timing budget: the sender updates `miso` 3 `clk` cycles after the `sclk` rise, plus 2 synchronizer cycles. HALF_PERIOD ≥ 6 therefore guarantees a stable sample.
- State LOW:
  - `sclk`=0 for HALF_PERIOD cycles.
  - At the end of LOW:
    - If bit counter ≠ 0: decrement it and go to HIGH.
    - If bit counter = 0: emit the word, then either go to HIGH for the next word or finish the frame.
- Word emit:
  - Occurs on the cycle LOW ends after bit 0 has been sampled.
  - `wr_en`=1 for exactly one cycle, `wr_data` = assembled word, `wr_addr` = word counter.
  - Word counter increments and bit counter reloads to 15.
  - `wr_data`/`wr_addr` hold their values until the next emit.
- Frame end:
  - After the emit of word N_WORDS-1: `done`=1 for one cycle (the same cycle as the final `wr_en`), `busy`=0, return to IDLE.
  - The frame consumes exactly 16·N_WORDS `sclk` rising edges.
- Latency: `start` to first `sclk` rise is 1 cycle. Word period is 32·HALF_PERIOD cycles.
- Boundary cases:
  - `start` while `busy`=1 is ignored.
  - `start` in the same cycle as `done` is ignored; a new `start` is accepted one cycle later.
  - N_WORDS=65536: `wr_addr` wraps to 0 only after the final word; there is no extra write.
  - N_WORDS=1: one `wr_en`, with `done` in the same cycle.
  - `rst` mid-frame aborts immediately:
    - `sclk` goes low with no further `wr_en` and no `done`.
    - The sender's bit alignment is then undefined; the system must reset both ends together.
- Arithmetic: counters wrap modulo their width. The shift register is exactly 16 bits.

Optional Feature:
- SERIAL_IN_CHECKSUM_EN defined:
  - `checksum` port exists.
  - It is cleared to 0 when `start` is accepted.
  - On every `wr_en`, `checksum` <= `checksum` + `wr_data` (mod 2^16).
  - The final value is valid from the `done` cycle and held until the next accepted `start` or `rst`.
- Not defined: no `checksum` port, no adder logic.

Test Plan:
- Sender model returns words 0xA5C3 and 0x0001; N_WORDS=2; pulse `start` → two `wr_en` pulses, (addr 0, 0xA5C3) then (addr 1, 0x0001); `done` with the 2nd `wr_en`; exactly 32 `sclk` rises.
- HALF_PERIOD=6 with a sender model using the 3-cycle `miso` update latency; pattern 0xFFFF, 0x0000, 0x8001 → all three words captured bit-exact.
- `start` pulsed again mid-frame and in the `done` cycle → ignored, with no extra `sclk` edges. `start` one cycle after `done` → new frame begins with `wr_addr`=0.
- Assert `rst` after 7 bits of word 0 → next cycle `sclk`=0, `busy`=0, and no `wr_en` or `done`. A fresh `start` afterwards → normal frame.
- N_WORDS=65536, incrementing data → last `wr_addr`=0xFFFF, a single `done`, 1048576 `sclk` rises.
- With SERIAL_IN_CHECKSUM_EN: words 0xFFFF, 0x0002 → `checksum`=0x0001 at `done`; it resets to 0 on the next `start`.
